// File: rtl/vga_scanout.sv
// VGA scan-out for the 1-bit screen buffer: timing, buffer read address and output alignment.
// Optional build macro VGA_SCANOUT_TEST_PATTERN_EN ORs a border/grid test pattern into the pixel stream.
module vga_scanout #(
    parameter int P_X_COORD_W      = 11,
    parameter int P_Y_COORD_W      = 11,
    parameter int P_LOG2_RAM_DEPTH = 19,
    parameter int P_DATA_W         = 1,
    parameter int P_CLK_DIV        = 2,
    parameter int P_H_VISIBLE      = 640,
    parameter int P_H_FRONT        = 16,
    parameter int P_H_SYNC         = 96,
    parameter int P_H_BACK         = 48,
    parameter int P_V_VISIBLE      = 480,
    parameter int P_V_FRONT        = 10,
    parameter int P_V_SYNC         = 2,
    parameter int P_V_BACK         = 33
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    output logic [P_LOG2_RAM_DEPTH-1:0] o_rd_addr,
    input  logic [P_DATA_W-1:0]         i_rd_data,
    output logic [P_X_COORD_W-1:0]      o_hcounter,
    output logic [P_Y_COORD_W-1:0]      o_vcounter,
    output logic                        o_hsync,
    output logic                        o_vsync,
    output logic                        o_video_on,
    output logic [P_DATA_W-1:0]         o_pixel_on,
    output logic                        o_vblank,
    output logic                        o_frame_start
);

    localparam int XW = P_X_COORD_W;
    localparam int YW = P_Y_COORD_W;
    localparam int AW = P_LOG2_RAM_DEPTH;

    localparam int H_TOTAL = P_H_VISIBLE + P_H_FRONT + P_H_SYNC + P_H_BACK;
    localparam int V_TOTAL = P_V_VISIBLE + P_V_FRONT + P_V_SYNC + P_V_BACK;

    localparam logic [XW-1:0] H_LAST     = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] H_VIS      = XW'(P_H_VISIBLE);
    localparam logic [XW-1:0] H_SYNC_ON  = XW'(P_H_VISIBLE + P_H_FRONT);
    localparam logic [XW-1:0] H_SYNC_OFF = XW'(P_H_VISIBLE + P_H_FRONT + P_H_SYNC);
    localparam logic [YW-1:0] V_LAST     = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] V_VIS      = YW'(P_V_VISIBLE);
    localparam logic [YW-1:0] V_SYNC_ON  = YW'(P_V_VISIBLE + P_V_FRONT);
    localparam logic [YW-1:0] V_SYNC_OFF = YW'(P_V_VISIBLE + P_V_FRONT + P_V_SYNC);

    logic tick;
    logic px_first;

    // px_first marks the first i_clk of each pixel so frame_start fires once per frame.
    generate
        if (P_CLK_DIV > 1) begin : g_div
            localparam int DW = $clog2(P_CLK_DIV);
            localparam logic [DW-1:0] DIV_LAST = DW'(P_CLK_DIV - 1);
            logic [DW-1:0] div;

            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    div <= '0;
                end else if (div == DIV_LAST) begin
                    div <= '0;
                end else begin
                    div <= div + DW'(1);
                end
            end

            assign tick     = (div == DIV_LAST);
            assign px_first = (div == '0);
        end else begin : g_nodiv
            assign tick     = 1'b1;
            assign px_first = 1'b1;
        end
    endgenerate

    logic [XW-1:0] hc;
    logic [YW-1:0] vc;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hc <= '0;
            vc <= '0;
        end else if (tick) begin
            if (hc == H_LAST) begin
                hc <= '0;
                if (vc == V_LAST) begin
                    vc <= '0;
                end else begin
                    vc <= vc + YW'(1);
                end
            end else begin
                hc <= hc + XW'(1);
            end
        end
    end

    logic          vis0;
    logic          hs0;
    logic          vs0;
    logic          vb0;
    logic          fs0;
    logic [AW-1:0] addr0;

    always_comb begin
        vis0  = (hc < H_VIS) && (vc < V_VIS);
        hs0   = !((hc >= H_SYNC_ON) && (hc < H_SYNC_OFF));
        vs0   = !((vc >= V_SYNC_ON) && (vc < V_SYNC_OFF));
        vb0   = (vc >= V_VIS);
        fs0   = px_first && (hc == '0) && (vc == '0);
        addr0 = '0;
        if (vis0) begin
            addr0 = AW'(P_H_VISIBLE) * AW'(vc) + AW'(hc);
        end
    end

    logic [XW-1:0] s1_hc;
    logic [YW-1:0] s1_vc;
    logic          s1_vis;
    logic          s1_hs;
    logic          s1_vs;
    logic          s1_vb;
    logic          s1_fs;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_rd_addr <= '0;
            s1_hc     <= '0;
            s1_vc     <= '0;
            s1_vis    <= 1'b0;
            s1_hs     <= 1'b1;
            s1_vs     <= 1'b1;
            s1_vb     <= 1'b0;
            s1_fs     <= 1'b0;
        end else begin
            o_rd_addr <= addr0;
            s1_hc     <= hc;
            s1_vc     <= vc;
            s1_vis    <= vis0;
            s1_hs     <= hs0;
            s1_vs     <= vs0;
            s1_vb     <= vb0;
            s1_fs     <= fs0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_hcounter    <= '0;
            o_vcounter    <= '0;
            o_video_on    <= 1'b0;
            o_hsync       <= 1'b1;
            o_vsync       <= 1'b1;
            o_vblank      <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            o_hcounter    <= s1_hc;
            o_vcounter    <= s1_vc;
            o_video_on    <= s1_vis;
            o_hsync       <= s1_hs;
            o_vsync       <= s1_vs;
            o_vblank      <= s1_vb;
            o_frame_start <= s1_fs;
        end
    end

    // The RAM's read register is the stage-2 storage for the data, so the pixel
    // is only gated here; adding a flop would put it one clock behind the syncs.
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    localparam logic [XW-1:0] H_VIS_LAST = XW'(P_H_VISIBLE - 1);
    localparam logic [YW-1:0] V_VIS_LAST = YW'(P_V_VISIBLE - 1);

    logic pat0;
    logic s1_pat;
    logic s2_pat;

    always_comb begin
        pat0 = (hc == '0) || (hc == H_VIS_LAST) || (vc == '0) || (vc == V_VIS_LAST)
            || (hc[5:0] == 6'd0) || (vc[5:0] == 6'd0);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s1_pat <= 1'b0;
            s2_pat <= 1'b0;
        end else begin
            s1_pat <= pat0;
            s2_pat <= s1_pat;
        end
    end

    assign o_pixel_on = (i_rd_data | {P_DATA_W{s2_pat}}) & {P_DATA_W{o_video_on}};
`else
    assign o_pixel_on = i_rd_data & {P_DATA_W{o_video_on}};
`endif

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a reduced geometry: per-cycle comparison against an arithmetic
// model of the scan position, plus measured line/frame/sync/alignment figures.
module tb_vga_scanout;

    localparam int DIV   = 2;
    localparam int HV    = 16;
    localparam int HF    = 2;
    localparam int HS    = 3;
    localparam int HB    = 3;
    localparam int VV    = 8;
    localparam int VF    = 1;
    localparam int VS    = 2;
    localparam int VB    = 2;
    localparam int HT    = HV + HF + HS + HB;
    localparam int VT    = VV + VF + VS + VB;
    localparam int AW    = 19;
    localparam int LINE  = HT * DIV;
    localparam int FRAME = HT * VT * DIV;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] rd_addr;
    logic          rd_data = 1'b0;
    logic [10:0]   hcnt;
    logic [10:0]   vcnt;
    logic          hsync, vsync, video_on, pixel_on, vblank, frame_start;

    bit mem [0:HV*VV-1];
    int n;
    int checks = 0;
    int fails  = 0;

    vga_scanout #(
        .P_X_COORD_W(11), .P_Y_COORD_W(11), .P_LOG2_RAM_DEPTH(AW), .P_DATA_W(1),
        .P_CLK_DIV(DIV),
        .P_H_VISIBLE(HV), .P_H_FRONT(HF), .P_H_SYNC(HS), .P_H_BACK(HB),
        .P_V_VISIBLE(VV), .P_V_FRONT(VF), .P_V_SYNC(VS), .P_V_BACK(VB)
    ) dut (
        .i_clk(clk),
        .i_reset_n(rst_n),
        .o_rd_addr(rd_addr),
        .i_rd_data(rd_data),
        .o_hcounter(hcnt),
        .o_vcounter(vcnt),
        .o_hsync(hsync),
        .o_vsync(vsync),
        .o_video_on(video_on),
        .o_pixel_on(pixel_on),
        .o_vblank(vblank),
        .o_frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Buffer RAM with a one-clock synchronous read.
    always @(posedge clk) begin
        if (int'(rd_addr) < HV * VV) rd_data <= mem[int'(rd_addr)];
        else                         rd_data <= 1'b0;
    end

    // Clocks since reset release: cycle n is the interval after the n-th rising edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s at n=%0d: actual=%0d required=%0d", nm, n, act, exp);
        end
    endtask

    function automatic int pos_h(input int m);
        return (m / DIV) % HT;
    endfunction

    function automatic int pos_v(input int m);
        return (m / (DIV * HT)) % VT;
    endfunction

    function automatic bit pattern(input int h, input int v);
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
        return (h == 0) || (h == HV - 1) || (v == 0) || (v == VV - 1) || (h % 64 == 0) || (v % 64 == 0);
`else
        return 1'b0;
`endif
    endfunction

    // Every cycle: outputs during cycle n show the scan position reached 2 clocks earlier.
    always @(negedge clk) begin : cmp
        int m, h, v;
        int e_addr, e_hc, e_vc, e_hs, e_vs, e_vid, e_vb, e_fs, e_pix;
        e_addr = 0; e_hc = 0; e_vc = 0; e_hs = 1; e_vs = 1;
        e_vid = 0; e_vb = 0; e_fs = 0; e_pix = 0;
        if (rst_n && n >= 1) begin
            m = n - 1;
            h = pos_h(m);
            v = pos_v(m);
            if (h < HV && v < VV) e_addr = v * HV + h;
        end
        if (rst_n && n >= 2) begin
            m = n - 2;
            h = pos_h(m);
            v = pos_v(m);
            e_hc  = h;
            e_vc  = v;
            e_vid = (h < HV && v < VV) ? 1 : 0;
            e_hs  = (h >= HV + HF && h < HV + HF + HS) ? 0 : 1;
            e_vs  = (v >= VV + VF && v < VV + VF + VS) ? 0 : 1;
            e_vb  = (v >= VV) ? 1 : 0;
            e_fs  = (h == 0 && v == 0 && (m % DIV) == 0) ? 1 : 0;
            e_pix = (e_vid == 1 && (mem[v * HV + h] || pattern(h, v))) ? 1 : 0;
        end
        check("rd_addr", rd_addr, e_addr);
        check("hcounter", hcnt, e_hc);
        check("vcounter", vcnt, e_vc);
        check("hsync", hsync, e_hs);
        check("vsync", vsync, e_vs);
        check("video_on", video_on, e_vid);
        check("vblank", vblank, e_vb);
        check("frame_start", frame_start, e_fs);
        check("pixel_on", pixel_on, e_pix);
    end

    int fs_first, fs_gap, hs_len, hs_h, vs_len, vs_v, vid_len;
    int pix_cnt, pix_h, pix_v, pix_n, addr_n;

    task automatic run(input int cycles);
        int fs_prev, hs_run, vs_run, vid_run;
        fs_prev = -1; hs_run = 0; vs_run = 0; vid_run = 0;
        fs_first = -1; fs_gap = -1; hs_len = -1; hs_h = -1; vs_len = -1; vs_v = -1;
        vid_len = -1; pix_cnt = 0; pix_h = -1; pix_v = -1; pix_n = -1; addr_n = -1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (frame_start) begin
                if (fs_prev < 0) fs_first = n;
                else if (fs_gap < 0) fs_gap = n - fs_prev;
                fs_prev = n;
            end
            if (!hsync) begin
                if (hs_run == 0) hs_h = int'(hcnt);
                hs_run++;
            end else if (hs_run > 0) begin
                if (hs_len < 0) hs_len = hs_run;
                hs_run = 0;
            end
            if (!vsync) begin
                if (vs_run == 0) vs_v = int'(vcnt);
                vs_run++;
            end else if (vs_run > 0) begin
                if (vs_len < 0) vs_len = vs_run;
                vs_run = 0;
            end
            if (video_on) vid_run++;
            else if (vid_run > 0) begin
                if (vid_len < 0) vid_len = vid_run;
                vid_run = 0;
            end
            if (pixel_on) begin
                if (pix_cnt == 0) begin
                    pix_h = int'(hcnt); pix_v = int'(vcnt); pix_n = n;
                end
                pix_cnt++;
            end
            if (int'(rd_addr) == 1 * HV + 5 && addr_n < 0) addr_n = n;
        end
    endtask

    // Asynchronous reset away from both clock edges; memory is reloaded while held.
    task automatic reset_and_load(input int mode, input int clocks);
        @(posedge clk);
        #2 rst_n = 1'b0;
        for (int i = 0; i < HV * VV; i++) begin
            case (mode)
                0: mem[i] = 1'($urandom_range(0, 1));
                1: mem[i] = (i == 1 * HV + 5);
                2: mem[i] = 1'b1;
                default: mem[i] = 1'b0;
            endcase
        end
        repeat (clocks) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        reset_and_load(0, 3);

        run(2 * FRAME + 10);
        check("first_frame_start_clock", fs_first, 2);
        check("frame_period", fs_gap, FRAME);
        check("hsync_low_clocks", hs_len, HS * DIV);
        check("hsync_start_hcounter", hs_h, HV + HF);
        check("vsync_low_clocks", vs_len, VS * LINE);
        check("vsync_start_vcounter", vs_v, VV + VF);
        check("video_on_clocks_per_line", vid_len, HV * DIV);

        run($urandom_range(50, 500));
        reset_and_load(1, 5);
        run(FRAME + 10);
        check("frame_start_after_midframe_reset", fs_first, 2);
`ifndef VGA_SCANOUT_TEST_PATTERN_EN
        check("single_pixel_clocks", pix_cnt, DIV);
        check("single_pixel_h", pix_h, 5);
        check("single_pixel_v", pix_v, 1);
        check("single_pixel_clock", pix_n, 2 + (1 * HT + 5) * DIV);
        check("addr_lead_clocks", pix_n - addr_n, 1);
`endif

        reset_and_load(2, 5);
        run(FRAME);
        check("all_ones_pixel_clocks", pix_cnt, HV * VV * DIV);

        reset_and_load(3, 2);
        run(FRAME);
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
        check("pattern_pixel_clocks", pix_cnt, (2 * HV + 2 * VV - 4) * DIV);
        check("pattern_first_pixel_h", pix_h, 0);
        check("pattern_first_pixel_v", pix_v, 0);
`else
        check("all_zero_pixel_clocks", pix_cnt, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
